incrementer_3bit: RTL and testbench
===================================

Name: incrementer_3bit

Overview:
- Registered binary incrementer: out = in + 1, modulo 2^WIDTH, with a carry-out flag.
- ALU building block. Default WIDTH=3 matches the original bit-level interface (I2..I0 in, O2..O0 out; I2/O2 = MSB).
- Built as a ripple chain of half adders with one output register stage.

Parameters:
- WIDTH, 3, operand width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand strobe; in is captured only when in_valid=1.
- in  input  WIDTH  operand; in[WIDTH-1] = MSB (I2 for WIDTH=3), in[0] = LSB (I0).
- out  output  WIDTH  registered in+1 (mod 2^WIDTH); out[WIDTH-1] = MSB (O2).
- carry_out  output  1  registered carry out of the MSB; 1 only when in was all-ones.
- out_valid  output  1  1 for exactly the cycle after an accepted operand.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high. All outputs are registers.
- Reset: on any clk edge with rst=1, out=0, carry_out=0, out_valid=0. rst overrides in_valid in the same cycle. Reset mid-stream discards the pending result.
- Arithmetic, combinational:
  - sum = in + 1, truncated to WIDTH bits.
  - carry = 1 iff in == 2^WIDTH-1.
  - Implementation: half-adder ripple. Stage 0 gets (in[0], 1); stage k gets (in[k], carry_{k-1}); final carry = carry_out.
- Latency: 1 cycle. With in_valid=1 at edge N (rst=0), the edge-N update is out=sum, carry_out=carry, out_valid=1.
- in_valid=0 at an edge (rst=0): out and carry_out hold their previous values; out_valid=0.
- Back-to-back operation: in_valid may be 1 every cycle, throughput 1/cycle. No backpressure and no ready signal.
- Wrap-around: in=all-ones gives out=0, carry_out=1. For every other value, carry_out=0.
- X/Z on in while in_valid=0 must not propagate to the outputs.
- No internal state other than the output registers.

Decomposition:
- Shared package alu_pkg: localparam DEFAULT_WIDTH=3. No typedefs required.
- One sub-module: half_adder (a, b -> s = a^b, c = a&b), instantiated WIDTH times via generate. The top level holds the generate loop and the output registers.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, in=3'b101 -> out=0, carry_out=0, out_valid=0 throughout; first valid result appears only after rst deasserts.
- Exhaustive sweep: stream in=0..7 on consecutive cycles with in_valid=1 -> one cycle later out=1,2,3,4,5,6,7,0; out_valid=1 each cycle. This mirrors the original bit-pattern sweep (I2I1I0 = 000..111).
- Wrap-around: in=3'b111 -> out=3'b000, carry_out=1; next in=3'b011 -> out=3'b100, carry_out=0.
- Hold: accept in=3'b010 (out=3'b011), then in_valid=0 with in toggling -> out stays 3'b011, carry_out=0, out_valid=0.
- Reset mid-stream: in_valid=1 with in=3'b110 in the same cycle as rst=1 -> next cycle out=0, out_valid=0, and the result 3'b111 never appears.
- Parameter check at WIDTH=8: in=8'hFF -> out=8'h00, carry_out=1; in=8'h7F -> out=8'h80, carry_out=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the small ALU building blocks.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 3;

endpackage : alu_pkg

// File: rtl/half_adder.sv
// Single-bit half adder: sum and carry of two input bits.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule : half_adder

// File: rtl/incrementer_3bit.sv
// Registered incrementer: out = in + 1 (mod 2^WIDTH) with carry-out, built
// from a ripple chain of half adders followed by one output register stage.
module incrementer_3bit
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             out_valid
);

    logic [WIDTH:0]   ripple;
    logic [WIDTH-1:0] sum;

    logic [WIDTH-1:0] out_d,       out_q;
    logic             carry_d,     carry_q;
    logic             out_valid_d, out_valid_q;

    // The constant 1 enters as the carry into bit 0, so each stage is a
    // half adder fed by its operand bit and the carry from the stage below.
    assign ripple[0] = 1'b1;

    for (genvar k = 0; k < WIDTH; k++) begin : g_stage
        half_adder u_ha (
            .a (in[k]),
            .b (ripple[k]),
            .s (sum[k]),
            .c (ripple[k+1])
        );
    end

    // Operand is only looked at when strobed, so an undriven bus while idle
    // never reaches the registers.
    always_comb begin
        out_d       = out_q;
        carry_d     = carry_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            out_d       = sum;
            carry_d     = ripple[WIDTH];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign carry_out = carry_q;
    assign out_valid = out_valid_q;

endmodule : incrementer_3bit

// File: tb/tb_incrementer_3bit.sv
// Scoreboard bench for incrementer_3bit at WIDTH=3 and WIDTH=8.
module tb_incrementer_3bit;

    typedef struct packed {
        logic [7:0] o;
        logic       c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       v3, v8;
    logic [2:0] in3;
    logic [7:0] in8;
    logic [2:0] out3;
    logic [7:0] out8;
    logic       c3, c8, ov3, ov8;

    int tests = 0;
    int fails = 0;

    exp_t q3[$];
    exp_t q8[$];

    always #5 clk = ~clk;

    incrementer_3bit #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in(in3),
        .out(out3), .carry_out(c3), .out_valid(ov3)
    );

    incrementer_3bit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in(in8),
        .out(out8), .carry_out(c8), .out_valid(ov8)
    );

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: whenever a DUT presents a result, pop and compare.
    always @(negedge clk) begin
        exp_t e;
        if (ov3) begin
            if (q3.size() == 0) begin
                tests++; fails++;
                $display("FAIL w3_unexpected: got out=%h c=%b, expected no result", out3, c3);
            end else begin
                e = q3.pop_front();
                check("w3_out", {1'b0, 5'd0, out3}, {1'b0, e.o});
                check("w3_carry", {8'd0, c3}, {8'd0, e.c});
            end
        end
        if (ov8) begin
            if (q8.size() == 0) begin
                tests++; fails++;
                $display("FAIL w8_unexpected: got out=%h c=%b, expected no result", out8, c8);
            end else begin
                e = q8.pop_front();
                check("w8_out", {1'b0, out8}, {1'b0, e.o});
                check("w8_carry", {8'd0, c8}, {8'd0, e.c});
            end
        end
    end

    logic [2:0] sweep_in  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [2:0] sweep_out [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    logic       sweep_c   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst = 1'b1; v3 = 1'b1; in3 = 3'b101; v8 = 1'b0; in8 = 8'h00;

        // Reset held for two edges with a strobed operand present.
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_out", {6'd0, out3}, 9'd0);
            check("rst_carry", {8'd0, c3}, 9'd0);
            check("rst_valid", {8'd0, ov3}, 9'd0);
        end
        rst = 1'b0;

        // Full sweep, back to back.
        for (int i = 0; i < 8; i++) begin
            in3 = sweep_in[i]; v3 = 1'b1;
            q3.push_back('{o: {5'd0, sweep_out[i]}, c: sweep_c[i]});
            step();
        end

        // Wrap then a plain increment.
        in3 = 3'b111; q3.push_back('{o: 8'h00, c: 1'b1}); step();
        in3 = 3'b011; q3.push_back('{o: 8'h04, c: 1'b0}); step();

        // Hold while idle with a wiggling operand.
        in3 = 3'b010; q3.push_back('{o: 8'h03, c: 1'b0}); step();
        v3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in3 = (i == 1) ? 3'bxxx : 3'(i * 5 + 1);
            step();
            check("hold_out", {6'd0, out3}, 9'd3);
            check("hold_carry", {8'd0, c3}, 9'd0);
            check("hold_valid", {8'd0, ov3}, 9'd0);
        end

        // Reset coinciding with a strobed operand discards it.
        in3 = 3'b110; v3 = 1'b1; rst = 1'b1;
        step();
        check("midrst_out", {6'd0, out3}, 9'd0);
        check("midrst_valid", {8'd0, ov3}, 9'd0);
        rst = 1'b0; v3 = 1'b0;
        step();
        check("midrst_after_out", {6'd0, out3}, 9'd0);
        check("midrst_after_valid", {8'd0, ov3}, 9'd0);

        // Wider instance.
        v8 = 1'b1;
        in8 = 8'hFF; q8.push_back('{o: 8'h00, c: 1'b1}); step();
        in8 = 8'h7F; q8.push_back('{o: 8'h80, c: 1'b0}); step();
        v8 = 1'b0;
        step();
        check("w8_hold_out", {1'b0, out8}, 9'h080);
        check("w8_hold_valid", {8'd0, ov8}, 9'd0);

        step();
        check("q3_drained", 9'(q3.size()), 9'd0);
        check("q8_drained", 9'(q8.size()), 9'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_incrementer_3bit
